sr_pipo: RTL and testbench



---
 rtl/sr_pkg.sv | 14 +
 rtl/sr_cell.sv | 37 +++
 rtl/sr_pipo.sv | 62 ++++++
 tb/tb_sr_pipo.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared constants and mode encodings
// for the sr_pipo register and its bit cells.
package sr_pkg;

  localparam int SR_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHL  = 2'b01,
    MODE_SHR  = 2'b10,
    MODE_LOAD = 2'b11
  } sr_mode_t;

endpackage

// File: rtl/sr_cell.sv
// sr_cell: one register bit with synchronous
// active-low clear and a 4:1 next-value mux.
module sr_cell
  import sr_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic     clk,
  input  logic     clr,
  input  sr_mode_t sel,
  input  logic     shl_bit,
  input  logic     shr_bit,
  input  logic     par_bit,
  output logic     q
);

  logic nxt;

  // next-value select by operating mode
  always_comb begin
    nxt = q;
    unique case (sel)
      MODE_HOLD: nxt = q;
      MODE_SHL:  nxt = shl_bit;
      MODE_SHR:  nxt = shr_bit;
      MODE_LOAD: nxt = par_bit;
      default:   nxt = q;
    endcase
  end

  // bit flop, clear wins over every mode
  always_ff @(posedge clk) begin
    if (!clr) q <= RST_BIT;
    else      q <= nxt;
  end

endmodule

// File: rtl/sr_pipo.sv
// sr_pipo: registered parallel-in/parallel-out word.
// SR_UNIVERSAL_EN adds hold/shift-left/shift-right/load modes.
module sr_pipo
  import sr_pkg::*;
#(
  parameter int               WIDTH   = SR_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] In,
`ifdef SR_UNIVERSAL_EN
  input  logic [1:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
`endif
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] q_int;
  logic [WIDTH-1:0] shl_v;
  logic [WIDTH-1:0] shr_v;
  sr_mode_t         sel;

`ifdef SR_UNIVERSAL_EN
  assign sel = sr_mode_t'(mode);

  for (genvar i = 0; i < WIDTH; i++) begin : g_nbr
    if (i == 0) begin : g_lo
      assign shl_v[i] = sin_l;
    end else begin : g_lo
      assign shl_v[i] = q_int[i-1];
    end
    if (i == WIDTH - 1) begin : g_hi
      assign shr_v[i] = sin_r;
    end else begin : g_hi
      assign shr_v[i] = q_int[i+1];
    end
  end
`else
  assign sel   = MODE_LOAD;
  assign shl_v = '0;
  assign shr_v = '0;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk     (clk),
      .clr     (clr),
      .sel     (sel),
      .shl_bit (shl_v[i]),
      .shr_bit (shr_v[i]),
      .par_bit (In[i]),
      .q       (q_int[i])
    );
  end

  assign Q = q_int;

endmodule

// File: tb/tb_sr_pipo.sv
// tb_sr_pipo: directed checks of sr_pipo at
// WIDTH=4 and WIDTH=8.
module tb_sr_pipo;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] d4  = '0;
  logic [7:0] d8  = '0;
  logic [3:0] q4;
  logic [7:0] q8;
  logic [1:0] mode  = 2'b11;
  logic       sin_l = 1'b0;
  logic       sin_r = 1'b0;
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  sr_pipo #(.WIDTH(4)) u4 (
    .clk   (clk),
    .clr   (clr),
    .In    (d4),
`ifdef SR_UNIVERSAL_EN
    .mode  (mode),
    .sin_l (sin_l),
    .sin_r (sin_r),
`endif
    .Q     (q4)
  );

  sr_pipo #(.WIDTH(8)) u8 (
    .clk   (clk),
    .clr   (clr),
    .In    (d8),
`ifdef SR_UNIVERSAL_EN
    .mode  (mode),
    .sin_l (sin_l),
    .sin_r (sin_r),
`endif
    .Q     (q8)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0;
    d4  = 4'b1111;
    d8  = 8'hFF;
    tick();
    chk("rst1", {4'h0, q4}, 8'h00);
    tick();
    chk("rst2", {4'h0, q4}, 8'h00);
    chk("rst8", q8, 8'h00);

    clr = 1'b1;
    d4  = 4'b1001;
    d8  = 8'hA5;
    tick();
    chk("ld1001", {4'h0, q4}, 8'h09);
    chk("ld8_a5", q8, 8'hA5);

    d4 = 4'b1010; tick();
    chk("st1010", {4'h0, q4}, 8'h0A);
    d4 = 4'b1011; tick();
    chk("st1011", {4'h0, q4}, 8'h0B);
    d4 = 4'b1110; tick();
    chk("st1110", {4'h0, q4}, 8'h0E);
    d4 = 4'b1111; tick();
    chk("st1111", {4'h0, q4}, 8'h0F);
    d4 = 4'b0000; tick();
    chk("st0000", {4'h0, q4}, 8'h00);

    d4  = 4'b1110;
    clr = 1'b0;
    tick();
    chk("mid_rst", {4'h0, q4}, 8'h00);
    chk("mid_rst8", q8, 8'h00);
    clr = 1'b1;
    tick();
    chk("post_rst", {4'h0, q4}, 8'h0E);
    chk("post_rst8", q8, 8'hA5);

    d4 = 4'b0000; tick();
    chk("pre_gl", {4'h0, q4}, 8'h00);
    @(negedge clk);
    d4 = 4'b0101; #1;
    d4 = 4'b1010; #1;
    chk("gl_nocomb", {4'h0, q4}, 8'h00);
    d4 = 4'b0101;
    tick();
    chk("glitch", {4'h0, q4}, 8'h05);

`ifdef SR_UNIVERSAL_EN
    mode = 2'b11;
    d4   = 4'b1001;
    tick();
    chk("u_load", {4'h0, q4}, 8'h09);
    mode  = 2'b01;
    sin_l = 1'b1;
    tick();
    chk("u_shl", {4'h0, q4}, 8'h03);
    mode  = 2'b10;
    sin_r = 1'b0;
    tick();
    chk("u_shr", {4'h0, q4}, 8'h01);
    mode = 2'b00;
    d4   = 4'b1111;
    tick();
    chk("u_hold1", {4'h0, q4}, 8'h01);
    tick();
    chk("u_hold2", {4'h0, q4}, 8'h01);
    tick();
    chk("u_hold3", {4'h0, q4}, 8'h01);
    mode = 2'b11;
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
